// File: rtl/axi_lite_sram_slave_pkg.sv
// Shared AXI-lite constants, response codes and FSM encodings for the SRAM slave.
package axi_lite_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  // Replace only the strobed bytes of old_word with the matching bytes of new_word.
  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] new_word,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_sram_slave_if.sv
// Single-master AXI-lite bus between the IFU/LSU arbiter and the SRAM slave.
interface axi_lite_sram_slave_if;
  import axi_lite_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_lite_sram_slave_mem_array.sv
// DEPTH_WORDS x 64 storage: one registered read port, one byte-enabled write port.
// A read and write on the same edge returns the pre-write word.
module axi_mem_array
  import axi_lite_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_en,
  input  logic                           rd_zero,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
  output logic [DATA_W-1:0]              rd_data,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic [STRB_W-1:0]              wr_strb
);

  logic [DATA_W-1:0] ram [DEPTH_WORDS];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Read-port next value; rd_zero substitutes the error payload for out-of-range reads.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (rd_zero) begin
        rd_data_d = {DATA_W{1'b0}};
      end else begin
        rd_data_d = ram[rd_idx];
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read-port output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= {DATA_W{1'b0}};
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  // Storage write; contents survive reset, but no write lands on a reset edge.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      ram[wr_idx] <= strb_merge(ram[wr_idx], wr_data, wr_strb);
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI-lite slave over a byte-strobed 64-bit SRAM with independent read/write FSMs,
// parameterised response latency, and DECERR for addresses outside the window.
module axi_lite_sram_slave
  import axi_lite_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h8000_0000,
  parameter int                DEPTH_WORDS = 4096,
  parameter int                RD_LAT      = 2,
  parameter int                WR_LAT      = 2
) (
  input logic                  clk,
  input logic                  rst,
  axi_lite_sram_slave_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2((RD_LAT > WR_LAT ? RD_LAT : WR_LAT) + 2);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH_WORDS * 8);

  // Address decode: the full offset compare also rejects addresses below the base.
  logic [ADDR_W-1:0] ar_off_s, aw_off_s;
  logic              ar_hit_s, aw_hit_s;
  logic [IDX_W-1:0]  ar_word_s, aw_word_s;

  assign ar_off_s  = bus.araddr - ADDR_BASE;
  assign aw_off_s  = bus.awaddr - ADDR_BASE;
  assign ar_hit_s  = (ar_off_s < SPAN);
  assign aw_hit_s  = (aw_off_s < SPAN);
  assign ar_word_s = ar_off_s[IDX_W+2:3];
  assign aw_word_s = aw_off_s[IDX_W+2:3];

  rd_state_e         r_state_q, r_state_d;
  logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
  logic [IDX_W-1:0]  ar_idx_q, ar_idx_d;
  logic              ar_oor_q, ar_oor_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rd_en_s, rd_zero_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic [DATA_W-1:0] rd_data_s;

  wr_state_e         w_state_q, w_state_d;
  logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
  logic              aw_have_q, aw_have_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic              aw_oor_q, aw_oor_d;
  logic              w_have_q, w_have_d;
  logic [DATA_W-1:0] wbuf_data_q, wbuf_data_d;
  logic [STRB_W-1:0] wbuf_strb_q, wbuf_strb_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              wr_en_s, wr_oor_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [STRB_W-1:0] wr_strb_s;

  // Read channel next state; the memory read fires on the edge that enters R_DATA.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    ar_idx_d  = ar_idx_q;
    ar_oor_d  = ar_oor_q;
    rresp_d   = rresp_q;
    rd_en_s   = 1'b0;
    rd_idx_s  = ar_idx_q;
    rd_zero_s = ar_oor_q;
    case (r_state_q)
      R_IDLE: begin
        if (bus.arvalid && arready_q) begin
          ar_idx_d = ar_word_s;
          ar_oor_d = !ar_hit_s;
          if (RD_LAT == 0) begin
            r_state_d = R_DATA;
            rd_en_s   = 1'b1;
            rd_idx_s  = ar_word_s;
            rd_zero_s = !ar_hit_s;
            rresp_d   = ar_hit_s ? RESP_OKAY : RESP_DECERR;
          end else begin
            r_state_d = R_WAIT;
            r_cnt_d   = CNT_W'(RD_LAT);
          end
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_WAIT: begin
        r_cnt_d = r_cnt_q - CNT_W'(1);
        if (r_cnt_q == CNT_W'(1)) begin
          r_state_d = R_DATA;
          rd_en_s   = 1'b1;
          rresp_d   = ar_oor_q ? RESP_DECERR : RESP_OKAY;
        end else begin
          r_state_d = R_WAIT;
        end
      end
      R_DATA: begin
        if (bus.rready) begin
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // A capture in the commit cycle itself is taken straight from the bus.
  assign wr_idx_s  = aw_have_q ? aw_idx_q : aw_word_s;
  assign wr_oor_s  = aw_have_q ? aw_oor_q : !aw_hit_s;
  assign wr_data_s = w_have_q ? wbuf_data_q : bus.wdata;
  assign wr_strb_s = w_have_q ? wbuf_strb_q : bus.wstrb;

  // Write channel next state; AW and W captured independently, commit on entry to W_RESP.
  always_comb begin
    w_state_d   = w_state_q;
    w_cnt_d     = w_cnt_q;
    aw_have_d   = aw_have_q;
    aw_idx_d    = aw_idx_q;
    aw_oor_d    = aw_oor_q;
    w_have_d    = w_have_q;
    wbuf_data_d = wbuf_data_q;
    wbuf_strb_d = wbuf_strb_q;
    bresp_d     = bresp_q;
    wr_en_s     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (bus.awvalid && awready_q) begin
          aw_have_d = 1'b1;
          aw_idx_d  = aw_word_s;
          aw_oor_d  = !aw_hit_s;
        end else begin
          aw_have_d = aw_have_q;
        end
        if (bus.wvalid && wready_q) begin
          w_have_d    = 1'b1;
          wbuf_data_d = bus.wdata;
          wbuf_strb_d = bus.wstrb;
        end else begin
          w_have_d = w_have_q;
        end
        if (aw_have_d && w_have_d) begin
          if (WR_LAT == 0) begin
            w_state_d = W_RESP;
            wr_en_s   = !wr_oor_s;
            bresp_d   = wr_oor_s ? RESP_DECERR : RESP_OKAY;
          end else begin
            w_state_d = W_WAIT;
            w_cnt_d   = CNT_W'(WR_LAT);
          end
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_WAIT: begin
        w_cnt_d = w_cnt_q - CNT_W'(1);
        if (w_cnt_q == CNT_W'(1)) begin
          w_state_d = W_RESP;
          wr_en_s   = !wr_oor_s;
          bresp_d   = wr_oor_s ? RESP_DECERR : RESP_OKAY;
        end else begin
          w_state_d = W_WAIT;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          w_state_d = W_IDLE;
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_have_d;
    wready_d  = (w_state_d == W_IDLE) && !w_have_d;
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Channel state and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q   <= R_IDLE;
      r_cnt_q     <= {CNT_W{1'b0}};
      ar_idx_q    <= {IDX_W{1'b0}};
      ar_oor_q    <= 1'b0;
      arready_q   <= 1'b1;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      w_state_q   <= W_IDLE;
      w_cnt_q     <= {CNT_W{1'b0}};
      aw_have_q   <= 1'b0;
      aw_idx_q    <= {IDX_W{1'b0}};
      aw_oor_q    <= 1'b0;
      w_have_q    <= 1'b0;
      wbuf_data_q <= {DATA_W{1'b0}};
      wbuf_strb_q <= {STRB_W{1'b0}};
      awready_q   <= 1'b1;
      wready_q    <= 1'b1;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
    end else begin
      r_state_q   <= r_state_d;
      r_cnt_q     <= r_cnt_d;
      ar_idx_q    <= ar_idx_d;
      ar_oor_q    <= ar_oor_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      w_state_q   <= w_state_d;
      w_cnt_q     <= w_cnt_d;
      aw_have_q   <= aw_have_d;
      aw_idx_q    <= aw_idx_d;
      aw_oor_q    <= aw_oor_d;
      w_have_q    <= w_have_d;
      wbuf_data_q <= wbuf_data_d;
      wbuf_strb_q <= wbuf_strb_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
    end
  end

  axi_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en_s),
    .rd_zero (rd_zero_s),
    .rd_idx  (rd_idx_s),
    .rd_data (rd_data_s),
    .wr_en   (wr_en_s),
    .wr_idx  (wr_idx_s),
    .wr_data (wr_data_s),
    .wr_strb (wr_strb_s)
  );

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rd_data_s;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave: scoreboarded reads/writes, latency,
// back-pressure, decode errors and mid-transaction reset.
module tb_axi_lite_sram_slave;
  import axi_lite_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          RL    = 2;
  localparam int          WL    = 2;
  localparam logic [31:0] SPAN  = 32'(DEPTH * 8);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_sram_slave_if bus ();

  axi_lite_sram_slave #(
    .ADDR_BASE  (BASE),
    .DEPTH_WORDS(DEPTH),
    .RD_LAT     (RL),
    .WR_LAT     (WL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
  } rexp_t;

  int          checks = 0;
  int          errors = 0;
  rexp_t       rq[$];
  logic [1:0]  bq[$];
  logic [63:0] mm[int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at a negedge after the R handshake.
  task automatic do_read(input logic [31:0] addr, input int hold, input string tag);
    logic [31:0] off;
    rexp_t       e;
    int          n;
    off = addr - BASE;
    if (off < SPAN) begin
      e.resp = 2'b00;
      e.data = mm.exists(int'(off >> 3)) ? mm[int'(off >> 3)] : 64'h0;
    end else begin
      e.resp = 2'b11;
      e.data = 64'h0;
    end
    rq.push_back(e);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    chk({tag, ".arready_T"}, 64'(bus.arready), 64'h1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    n = 1;
    while (bus.rvalid !== 1'b1 && n <= 20) begin
      chk({tag, ".arready_wait"}, 64'(bus.arready), 64'h0);
      @(negedge clk);
      n++;
    end
    chk({tag, ".r_latency"}, 64'(n), 64'(1 + RL));
    chk({tag, ".arready_rvalid"}, 64'(bus.arready), 64'h0);
    e = rq.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk({tag, ".hold_rvalid"}, 64'(bus.rvalid), 64'h1);
      chk({tag, ".hold_rdata"}, bus.rdata, e.data);
      chk({tag, ".hold_rresp"}, 64'(bus.rresp), 64'(e.resp));
      chk({tag, ".hold_arready"}, 64'(bus.arready), 64'h0);
      @(negedge clk);
    end
    chk({tag, ".rdata"}, bus.rdata, e.data);
    chk({tag, ".rresp"}, 64'(bus.rresp), 64'(e.resp));
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    chk({tag, ".rvalid_after"}, 64'(bus.rvalid), 64'h0);
    chk({tag, ".arready_after"}, 64'(bus.arready), 64'h1);
  endtask

  // w_lead = cycles W handshake precedes AW handshake (0 = same cycle).
  task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input int w_lead, input int hold, input string tag);
    logic [31:0] off;
    logic [63:0] word;
    logic [1:0]  eresp;
    int          n;
    int          idx;
    off = addr - BASE;
    idx = int'(off >> 3);
    if (off < SPAN) begin
      word = mm.exists(idx) ? mm[idx] : 64'h0;
      for (int b = 0; b < 8; b++) begin
        if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
      end
      mm[idx] = word;
      bq.push_back(2'b00);
    end else begin
      bq.push_back(2'b11);
    end
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    chk({tag, ".wready_T"}, 64'(bus.wready), 64'h1);
    if (w_lead == 0) begin
      bus.awaddr  = addr;
      bus.awvalid = 1'b1;
      chk({tag, ".awready_T"}, 64'(bus.awready), 64'h1);
    end
    for (int i = 1; i <= w_lead; i++) begin
      @(negedge clk);
      bus.wvalid = 1'b0;
      chk({tag, ".wready_held"}, 64'(bus.wready), 64'h0);
      chk({tag, ".bvalid_early"}, 64'(bus.bvalid), 64'h0);
      if (i == w_lead) begin
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        chk({tag, ".awready_T"}, 64'(bus.awready), 64'h1);
      end
    end
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    n = 1;
    while (bus.bvalid !== 1'b1 && n <= 20) begin
      chk({tag, ".awready_wait"}, 64'(bus.awready), 64'h0);
      chk({tag, ".wready_wait"}, 64'(bus.wready), 64'h0);
      @(negedge clk);
      n++;
    end
    chk({tag, ".b_latency"}, 64'(n), 64'(1 + WL));
    eresp = bq.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk({tag, ".hold_bvalid"}, 64'(bus.bvalid), 64'h1);
      chk({tag, ".hold_bresp"}, 64'(bus.bresp), 64'(eresp));
      @(negedge clk);
    end
    chk({tag, ".bresp"}, 64'(bus.bresp), 64'(eresp));
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    chk({tag, ".bvalid_after"}, 64'(bus.bvalid), 64'h0);
    chk({tag, ".awready_after"}, 64'(bus.awready), 64'h1);
    chk({tag, ".wready_after"}, 64'(bus.wready), 64'h1);
  endtask

  initial begin
    bus.araddr  = 32'h0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    bus.awaddr  = 32'h0;
    bus.awvalid = 1'b0;
    bus.wdata   = 64'h0;
    bus.wstrb   = 8'h0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst.arready", 64'(bus.arready), 64'h1);
    chk("rst.awready", 64'(bus.awready), 64'h1);
    chk("rst.wready", 64'(bus.wready), 64'h1);
    chk("rst.rvalid", 64'(bus.rvalid), 64'h0);
    chk("rst.bvalid", 64'(bus.bvalid), 64'h0);
    chk("rst.rdata", bus.rdata, 64'h0);
    chk("rst.rresp", 64'(bus.rresp), 64'h0);
    chk("rst.bresp", 64'(bus.bresp), 64'h0);

    do_write(BASE, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0, "w0");
    do_read(BASE, 0, "r0");

    do_write(BASE + 32'h10, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, "w10_full");
    do_write(BASE + 32'h10, 64'hFFFF_FFFF_AAAA_AAAA, 8'h0F, 0, 0, "w10_low");
    do_read(BASE + 32'h10, 0, "r10");
    do_read(BASE + 32'h17, 0, "r17_lowbits");

    do_write(BASE + 32'h18, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 3, 0, "w18_wfirst");
    do_write(BASE + 32'h18, 64'h5A5A_5A5A_5A5A_5A5A, 8'h00, 0, 0, "w18_nostrb");
    do_read(BASE + 32'h18, 0, "r18");

    do_write(BASE + SPAN - 32'h8, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, 0, "wlast");
    do_read(BASE + SPAN - 32'h8, 0, "rlast");

    do_read(32'h7FFF_FFF8, 0, "r_below");
    do_write(32'h8000_8000, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, 0, 0, "w_above");
    do_read(BASE, 0, "r0_after_oor");
    do_read(BASE + 32'h10, 0, "r10_after_oor");

    do_read(BASE + 32'h18, 5, "r18_hold");
    do_write(BASE + 32'h20, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 5, "w20_hold");
    do_read(BASE + 32'h20, 0, "r20");

    // Reset while both channels sit in their wait states; the write must be dropped.
    bus.araddr  = BASE + 32'h10;
    bus.arvalid = 1'b1;
    bus.awaddr  = BASE + 32'h10;
    bus.awvalid = 1'b1;
    bus.wdata   = 64'h5555_5555_5555_5555;
    bus.wstrb   = 8'hFF;
    bus.wvalid  = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    chk("mid.arready_busy", 64'(bus.arready), 64'h0);
    chk("mid.awready_busy", 64'(bus.awready), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid.rvalid", 64'(bus.rvalid), 64'h0);
    chk("mid.bvalid", 64'(bus.bvalid), 64'h0);
    chk("mid.arready", 64'(bus.arready), 64'h1);
    chk("mid.awready", 64'(bus.awready), 64'h1);
    chk("mid.wready", 64'(bus.wready), 64'h1);
    chk("mid.rdata", bus.rdata, 64'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid.rvalid_quiet", 64'(bus.rvalid), 64'h0);
      chk("mid.bvalid_quiet", 64'(bus.bvalid), 64'h0);
    end
    do_read(BASE + 32'h10, 0, "r10_post_rst");
    do_read(BASE, 0, "r0_post_rst");

    chk("sb.empty", 64'(rq.size() + bq.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
